// File: rtl/eth_rx_fcs_check.sv
// rtl/eth_rx_fcs_check.sv - Ethernet RX CRC-32 check, FCS strip and frame status marker (optional stats: ETH_RX_STATS_EN)
module eth_rx_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_eop,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_eop
`ifdef ETH_RX_STATS_EN
    ,
    output logic [15:0] good_frames,
    output logic [15:0] bad_frames
`endif
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] CNT_MAX     = 11'h7FF;
    localparam logic [10:0] MIN_CNT     = 11'(MIN_LEN);
    localparam logic [10:0] MAX_CNT     = 11'(MAX_LEN);

    // Reflected CRC-32 advanced by one byte, LSB first, no final inversion
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ({1'b0, r[31:1]} ^ CRC_POLY) : {1'b0, r[31:1]};
        end
        return r;
    endfunction

    // dly[0] is the newest byte, dly[3] the oldest; a byte leaves only once
    // four younger bytes are behind it, so the trailing FCS never escapes
    logic [3:0][7:0] dly;
    logic [2:0]      fill;
    logic [31:0]     crc;
    logic [10:0]     byte_cnt;

    logic       crc_ok;
    logic       runt;
    logic       giant;
    logic [7:0] status;

    // Frame verdict from the state accumulated so far; sampled on in_eop
    always_comb begin
        crc_ok = (crc == CRC_RESIDUE);
        runt   = (byte_cnt < MIN_CNT);
        giant  = (byte_cnt > MAX_CNT);
        status = {5'b0, giant, runt, crc_ok};
    end

    // Byte path: CRC/count/delay-line update, payload emit and eop marker
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            dly       <= '0;
            fill      <= '0;
            crc       <= CRC_INIT;
            byte_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_eop   <= 1'b0;
            if (in_eop) begin
                // eop wins over a coincident byte; that byte is dropped
                out_eop  <= 1'b1;
                out_data <= status;
                dly      <= '0;
                fill     <= '0;
                crc      <= CRC_INIT;
                byte_cnt <= '0;
            end else if (in_valid) begin
                crc <= crc_byte(crc, in_data);
                if (byte_cnt != CNT_MAX) begin
                    byte_cnt <= byte_cnt + 11'd1;
                end
                dly <= {dly[2:0], in_data};
                if (fill == 3'd4) begin
                    out_valid <= 1'b1;
                    out_data  <= dly[3];
                end else begin
                    fill <= fill + 3'd1;
                end
            end
        end
    end

`ifdef ETH_RX_STATS_EN
    // Saturating good/bad frame counters, updated alongside the eop marker
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            good_frames <= '0;
            bad_frames  <= '0;
        end else if (in_eop) begin
            if (status == 8'h01) begin
                if (good_frames != 16'hFFFF) begin
                    good_frames <= good_frames + 16'd1;
                end
            end else begin
                if (bad_frames != 16'hFFFF) begin
                    bad_frames <= bad_frames + 16'd1;
                end
            end
        end
    end
`endif

endmodule
